div_unit: RTL and testbench

//   Multi-cycle radix-2 restoring divider for DIV/DIVU in the myCPU datapath.

---
 rtl/div_unit.sv | 136 +++++++++++++
 tb/tb_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Operands are reduced to magnitudes at acceptance. WIDTH restoring steps
// follow, then one cycle re-applies the signs. Division by zero
// short-circuits to quotient = all-ones and remainder = dividend.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // Two's-complement negate when n is set; also used for magnitudes.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic n);
    return n ? ('0 - v) : v;
  endfunction

  assign accept = (state == IDLE) && start && !cancel;
  assign mag_a  = cond_neg(a, is_signed & a[WIDTH-1]);
  assign mag_b  = cond_neg(b, is_signed & b[WIDTH-1]);

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor
  // on WIDTH+1 bits, and keep the difference when it does not underflow.
  // rem < dvsr always holds, so the kept difference fits in WIDTH bits.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvsr});
    diff   = rem_sh - {1'b0, dvsr};
    rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ge};
  end

  // Datapath working registers: loaded at acceptance, stepped in CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvsr  <= mag_b;
      quo   <= mag_a;
      rem   <= '0;
      neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed & a[WIDTH-1];
    end else if (state == CALC) begin
      rem <= rem_nx;
      quo <= quo_nx;
    end
  end

  // Control FSM and registered results; cancel takes priority everywhere.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            cnt <= '0;
            if (b == '0) begin
              quotient  <= '1;
              remainder <= a;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= SIGN;
          end
        end
        SIGN: begin
          busy <= 1'b0;
          if (cancel) begin
            state <= IDLE;
          end else begin
            quotient  <= cond_neg(quo, neg_q);
            remainder <= cond_neg(rem, neg_r);
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: scoreboard queue filled at issue, monitor pops on done.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [63:0] exp_q[$];

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input bit s);
    longint sx, sy, qq, rr;
    logic [31:0] uq, ur;
    if (y == 32'd0) return {32'hFFFF_FFFF, x};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      qq = sx / sy;
      rr = sx % sy;
      return {qq[31:0], rr[31:0]};
    end
    uq = x / y;
    ur = x % y;
    return {uq, ur};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_done: got q=0x%08h r=0x%08h expected no result",
                 quotient, remainder);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("quotient", quotient, e[63:32]);
        chk("remainder", remainder, e[31:0]);
      end
    end
  end

  // Issue one operation and watch latency, busy length and pulse width.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit s);
    int n, busy_n, lat;
    lat = (y == 32'd0) ? 0 : 33;
    @(negedge clk);
    start = 1'b1; a = x; b = y; is_signed = s;
    exp_q.push_back(model(x, y, s));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom;
    n = 0; busy_n = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk_cnt++;
      $display("FAIL done_timeout: got no done after %0d cycles expected %0d", n, lat);
    end else begin
      chk("latency", n, lat);
      chk("busy_cycles", busy_n, lat);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
    end
  endtask

  int dn;
  logic [31:0] rx, ry;

  initial begin
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);

    // Cancel at E10 of 50/3 after a completed 100/7.
    run_op(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 32'd50; b = 32'd3; is_signed = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chk("cancel_no_done", dn, 0);
    chk("cancel_hold_q", quotient, 32'd14);
    chk("cancel_hold_r", remainder, 32'd2);
    run_op(32'd50, 32'd3, 1'b0);

    // Start and cancel together in IDLE: nothing accepted.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd4;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", {31'd0, busy}, 32'd0);

    // Start pulsed mid-operation at E5 is ignored.
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3; is_signed = 1'b0;
    exp_q.push_back(model(32'd1000, 32'd3, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; a = 32'd77; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    while (done !== 1'b1 && dn < 60) begin
      @(negedge clk);
      dn++;
    end
    chk("ignored_start_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("ignored_start_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset at E20 wipes the operation and outputs.
    @(negedge clk);
    start = 1'b1; a = 32'd12345; b = 32'd11; is_signed = 1'b0;
    exp_q.push_back(model(32'd12345, 32'd11, 1'b0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_q", quotient, 32'd0);
    chk("arst_r", remainder, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_op(32'd12345, 32'd11, 1'b0);

    // Randomized operations, including small divisors and zero.
    for (int i = 0; i < 24; i++) begin
      rx = $urandom;
      case ($urandom_range(0, 3))
        0: ry = 32'd0;
        1: ry = $urandom_range(1, 9);
        2: ry = -$urandom_range(1, 9);
        default: ry = $urandom;
      endcase
      run_op(rx, ry, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

endmodule
